// File: rtl/axi_read_responder.sv
// AXI slave read-data responder: pops AR requests from a show-ahead FIFO and
// returns each burst on the R channel with RDATA equal to the beat address.
module axi_read_responder #(
  parameter int ADDR_BITWIDTH = 32,
  parameter int ID_BITWIDTH   = 1,
  parameter int DATA_BITWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_BITWIDTH-1:0] req_ADDR,
  input  logic [ID_BITWIDTH-1:0]   req_ID,
  input  logic [7:0]               req_LEN,
  input  logic [2:0]               req_SIZE,
  input  logic [1:0]               req_BURST,
  input  logic                     req_empty,
  output logic                     req_read,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [DATA_BITWIDTH-1:0] RDATA,
  output logic [ID_BITWIDTH-1:0]   RID,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     busy
);

  localparam logic [2:0] MAX_SIZE   = 3'($clog2(DATA_BITWIDTH / 8));
  localparam logic [1:0] STEP_FIXED = 2'd0;
  localparam logic [1:0] STEP_INCR  = 2'd1;
  localparam logic [1:0] STEP_WRAP  = 2'd2;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state_reg, state_next;
  logic [ID_BITWIDTH-1:0]   id_reg, id_next;
  logic [7:0]               len_reg, len_next;
  logic [2:0]               size_reg, size_next;
  logic [1:0]               step_reg, step_next;
  logic                     err_reg, err_next;
  logic [ADDR_BITWIDTH-1:0] addr_reg, addr_next;
  logic [7:0]               beat_reg, beat_next;

  logic                     handshake, load, wrap_len_ok, req_err;
  logic [ADDR_BITWIDTH-1:0] bytes, aligned, incr_addr, wsize, lower, wrap_addr;
  logic [2:0]               wrap_log;

  assign busy      = (state_reg == BURST);
  assign RVALID    = busy;
  assign RLAST     = busy && (beat_reg == len_reg);
  assign RID       = id_reg;
  assign RRESP     = {err_reg, 1'b0};
  assign RDATA     = DATA_BITWIDTH'(addr_reg);
  assign handshake = RVALID && RREADY;
  assign load      = !reset && !req_empty && (state_reg == IDLE || (handshake && RLAST));
  assign req_read  = load;

  assign wrap_len_ok = (req_LEN == 8'd1) || (req_LEN == 8'd3) ||
                       (req_LEN == 8'd7) || (req_LEN == 8'd15);
  assign req_err     = (req_BURST == 2'd3) || (req_BURST == 2'd2 && !wrap_len_ok) ||
                       (req_SIZE > MAX_SIZE);

  // Step mode is resolved at load time so illegal bursts step like their fallback type.
  assign bytes     = ADDR_BITWIDTH'(1) << size_reg;
  assign aligned   = addr_reg & ~(bytes - ADDR_BITWIDTH'(1));
  assign incr_addr = aligned + bytes;

  always_comb begin
    case (len_reg)
      8'd1:    wrap_log = 3'd1;
      8'd3:    wrap_log = 3'd2;
      8'd7:    wrap_log = 3'd3;
      default: wrap_log = 3'd4;
    endcase
  end

  assign wsize     = bytes << wrap_log;
  assign lower     = addr_reg & ~(wsize - ADDR_BITWIDTH'(1));
  assign wrap_addr = (incr_addr == lower + wsize) ? lower : incr_addr;

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    len_next   = len_reg;
    size_next  = size_reg;
    step_next  = step_reg;
    err_next   = err_reg;
    addr_next  = addr_reg;
    beat_next  = beat_reg;
    if (load) begin
      state_next = BURST;
      id_next    = req_ID;
      len_next   = req_LEN;
      size_next  = req_SIZE;
      err_next   = req_err;
      addr_next  = req_ADDR;
      beat_next  = 8'd0;
      if (req_BURST == 2'd3)
        step_next = STEP_FIXED;
      else if (req_BURST == 2'd2 && !wrap_len_ok)
        step_next = STEP_INCR;
      else
        step_next = req_BURST;
    end else if (handshake) begin
      if (RLAST) begin
        state_next = IDLE;
      end else begin
        beat_next = beat_reg + 8'd1;
        case (step_reg)
          STEP_INCR: addr_next = incr_addr;
          STEP_WRAP: addr_next = wrap_addr;
          default:   addr_next = addr_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      id_reg    <= '0;
      len_reg   <= '0;
      size_reg  <= '0;
      step_reg  <= STEP_FIXED;
      err_reg   <= 1'b0;
      addr_reg  <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
      len_reg   <= len_next;
      size_reg  <= size_next;
      step_reg  <= step_next;
      err_reg   <= err_next;
      addr_reg  <= addr_next;
      beat_reg  <= beat_next;
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: request FIFO model plus a burst-expansion
// reference that predicts every R beat, pop strobe and valid cycle.
module tb_axi_read_responder;

  localparam int AW = 32;
  localparam int IW = 1;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] req_ADDR;
  logic [IW-1:0] req_ID;
  logic [7:0]    req_LEN;
  logic [2:0]    req_SIZE;
  logic [1:0]    req_BURST;
  logic          req_empty;
  logic          req_read;
  logic          RVALID;
  logic          RREADY;
  logic [DW-1:0] RDATA;
  logic [IW-1:0] RID;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          busy;

  always #5 clk = ~clk;

  axi_read_responder #(.ADDR_BITWIDTH(AW), .ID_BITWIDTH(IW), .DATA_BITWIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_ADDR(req_ADDR), .req_ID(req_ID), .req_LEN(req_LEN), .req_SIZE(req_SIZE),
    .req_BURST(req_BURST), .req_empty(req_empty), .req_read(req_read),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RID(RID), .RRESP(RRESP),
    .RLAST(RLAST), .busy(busy)
  );

  // Show-ahead request FIFO model
  logic [AW-1:0] f_addr  [4096];
  logic [IW-1:0] f_id    [4096];
  logic [7:0]    f_len   [4096];
  logic [2:0]    f_size  [4096];
  logic [1:0]    f_burst [4096];
  int            rd_ptr = 0;
  int            wr_ptr = 0;
  logic [11:0]   rd_idx;

  assign rd_idx    = rd_ptr[11:0];
  assign req_empty = (rd_ptr == wr_ptr);
  assign req_ADDR  = f_addr[rd_idx];
  assign req_ID    = f_id[rd_idx];
  assign req_LEN   = f_len[rd_idx];
  assign req_SIZE  = f_size[rd_idx];
  assign req_BURST = f_burst[rd_idx];

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  beat_t cur_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  int    n_txn = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_req(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    f_addr[wr_ptr[11:0]]  = a;
    f_id[wr_ptr[11:0]]    = id;
    f_len[wr_ptr[11:0]]   = len;
    f_size[wr_ptr[11:0]]  = size;
    f_burst[wr_ptr[11:0]] = burst;
    wr_ptr++;
  endtask

  // Expand one request into its full list of expected beats.
  task automatic build_burst(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    bit            wrap_ok, err;
    int            mode;
    logic [AW-1:0] nbytes, start_al, wsize, lower, off;
    beat_t         b;
    wrap_ok  = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    err      = (burst == 3) || (burst == 2 && !wrap_ok) || (size > 3'd2);
    mode     = (burst == 3) ? 0 : ((burst == 2 && !wrap_ok) ? 1 : int'(burst));
    nbytes   = AW'(1) << size;
    start_al = a & ~(nbytes - 1);
    wsize    = nbytes * (AW'(len) + 1);
    lower    = a & ~(wsize - 1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == 0 || mode == 0) b.addr = a;
      else if (mode == 1)      b.addr = start_al + AW'(i) * nbytes;
      else begin
        off    = (start_al - lower + AW'(i) * nbytes) % wsize;
        b.addr = lower + off;
      end
      b.id   = id;
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      cur_q.push_back(b);
    end
  endtask

  task automatic do_cycle(input bit rr);
    bit exp_valid, exp_pop;
    @(negedge clk);
    RREADY = rr;
    #1;
    exp_valid = (cur_q.size() > 0);
    check_val("rvalid", 64'(RVALID), 64'(exp_valid));
    check_val("busy", 64'(busy), 64'(exp_valid));
    if (exp_valid) begin
      check_val("rdata", 64'(RDATA), 64'(cur_q[0].addr));
      check_val("rid", 64'(RID), 64'(cur_q[0].id));
      check_val("rresp", 64'(RRESP), 64'(cur_q[0].resp));
      check_val("rlast", 64'(RLAST), 64'(cur_q[0].last));
    end else begin
      check_val("rlast_idle", 64'(RLAST), 64'd0);
    end
    exp_pop = (rd_ptr != wr_ptr) && (!exp_valid || (rr && cur_q.size() == 1));
    check_val("req_read", 64'(req_read), 64'(exp_pop));
    @(posedge clk);
    #1;
    if (exp_valid && rr) begin
      if (cur_q[0].last) begin
        n_txn++;
        $display("txn %0d: burst done, last addr=%h id=%0d resp=%b", n_txn, cur_q[0].addr,
                 cur_q[0].id, cur_q[0].resp);
      end
      void'(cur_q.pop_front());
    end
    if (exp_pop) begin
      build_burst(f_addr[rd_idx], f_id[rd_idx], f_len[rd_idx], f_size[rd_idx], f_burst[rd_idx]);
      rd_ptr++;
    end
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_rvalid", 64'(RVALID), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_rlast", 64'(RLAST), 64'd0);
    check_val("rst_req_read", 64'(req_read), 64'd0);
    $display("txn reset: in-flight burst abandoned with %0d beats left", cur_q.size());
    cur_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [6:0] bp_pattern;
  logic [7:0] rlen;
  logic [2:0] rsize;

  initial begin
    bp_pattern = 7'b1101001;  // bit i = RREADY in cycle i: 1,0,0,1,0,1,1
    reset  = 1'b1;
    RREADY = 1'b0;
    push_req(32'h100, 1'b1, 8'd3, 3'd2, 2'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("reset_rvalid", 64'(RVALID), 64'd0);
    check_val("reset_rlast", 64'(RLAST), 64'd0);
    check_val("reset_rdata", 64'(RDATA), 64'd0);
    check_val("reset_rid", 64'(RID), 64'd0);
    check_val("reset_rresp", 64'(RRESP), 64'd0);
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_req_read", 64'(req_read), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed INCR, WRAP, unaligned INCR, FIXED; preloaded so they run back to back
    push_req(32'h38, 1'b0, 8'd3, 3'd2, 2'd2);
    push_req(32'h101, 1'b1, 8'd2, 3'd2, 2'd1);
    push_req(32'h200, 1'b0, 8'd2, 3'd2, 2'd0);
    push_req(32'h600, 1'b1, 8'd1, 3'd2, 2'd1);
    push_req(32'h700, 1'b0, 8'd0, 3'd2, 2'd1);
    repeat (24) do_cycle(1'b1);

    // Backpressure on an 8-beat INCR burst
    push_req(32'h1000, 1'b1, 8'd7, 3'd2, 2'd1);
    for (int i = 0; i < 30; i++) do_cycle(bp_pattern[i % 7]);

    // Illegal requests: reserved burst, WRAP with LEN=2, oversize beat
    push_req(32'h300, 1'b0, 8'd1, 3'd2, 2'd3);
    push_req(32'h400, 1'b1, 8'd2, 3'd2, 2'd2);
    push_req(32'h500, 1'b0, 8'd1, 3'd3, 2'd1);
    repeat (15) do_cycle(1'b1);

    // Reset in the middle of a LEN=7 burst, then the next request starts cleanly
    push_req(32'h800, 1'b1, 8'd7, 3'd2, 2'd1);
    push_req(32'h900, 1'b0, 8'd0, 3'd2, 2'd1);
    for (int i = 0; i < 20 && !(cur_q.size() == 6 && rd_ptr == wr_ptr - 1); i++) do_cycle(1'b1);
    do_reset_mid();
    repeat (10) do_cycle(1'b1);

    // Randomized traffic with random backpressure and occasional resets
    for (int c = 0; c < 2500; c++) begin
      if ((wr_ptr - rd_ptr) < 4 && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0: rlen = 8'd0;
          1: rlen = 8'd1;
          2: rlen = 8'd3;
          3: rlen = 8'd7;
          4: rlen = 8'd15;
          default: rlen = 8'($urandom_range(0, 20));
        endcase
        rsize = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
        push_req($urandom, IW'($urandom_range(0, 1)), rlen, rsize, 2'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 399) == 0) do_reset_mid();
      else do_cycle($urandom_range(0, 3) != 0);
    end

    repeat (300) do_cycle(1'b1);
    check_val("drain_empty", 64'(req_empty), 64'd1);
    check_val("drain_idle", 64'(RVALID), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
